performance_ch_avg_collector: RTL and testbench

- Consumer side of the per-channel performance counters: serves the program, read and erase latency counters of one channel.
- When a counter raises its ready flag, the block captures that counter's latency sum and request count, computes average latency = sum / req_cnt with an iterative divider, and stores the result in a host-visible register.
- It then pulses the counter's copy-complete input so the counter clears and restarts.
- Sits between the channel counters and the performance-monitor slave register file.

---
 rtl/performance_ch_avg_collector.sv | 185 ++++++++++++++++++
 tb/tb_performance_ch_avg_collector.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/performance_ch_avg_collector.sv
// Average-latency collector for one channel: serves the prog/read/erase counters in turn,
// divides each latency sum by its request count and acknowledges the counter with a pulse.
module performance_ch_avg_collector #(
    parameter int unsigned CNT_WD       = 32,
    parameter int unsigned PROG_REQ_WD  = 10,
    parameter int unsigned READ_REQ_WD  = 12,
    parameter int unsigned ERASE_REQ_WD = 10
) (
    input  logic                    i_bus_clk,
    input  logic                    i_bus_rst,
    input  logic                    i_prog_ready,
    input  logic [CNT_WD-1:0]       i_prog_cnt,
    input  logic [PROG_REQ_WD-1:0]  i_prog_req_cnt,
    output logic                    o_prog_cp_cmplt,
    input  logic                    i_read_ready,
    input  logic [CNT_WD-1:0]       i_read_cnt,
    input  logic [READ_REQ_WD-1:0]  i_read_req_cnt,
    output logic                    o_read_cp_cmplt,
    input  logic                    i_erase_ready,
    input  logic [CNT_WD-1:0]       i_erase_cnt,
    input  logic [ERASE_REQ_WD-1:0] i_erase_req_cnt,
    output logic                    o_erase_cp_cmplt,
    output logic [CNT_WD-1:0]       o_prog_avg,
    output logic [CNT_WD-1:0]       o_read_avg,
    output logic [CNT_WD-1:0]       o_erase_avg,
    output logic [2:0]              o_valid,
    input  logic [2:0]              i_clr,
    output logic                    o_busy
);

    localparam int unsigned DIV_CW = $clog2(CNT_WD);
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(CNT_WD - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_DIV, ST_STORE, ST_ACK} state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d, last_q, last_d;
    logic [2:0]          lock_q, lock_d, valid_q, valid_d, cp_q, cp_d;
    logic [CNT_WD:0]     rem_q, rem_d;
    logic [CNT_WD-1:0]   quo_q, quo_d, dvsr_q, dvsr_d;
    logic [DIV_CW-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_WD-1:0]   prog_avg_q, prog_avg_d, read_avg_q, read_avg_d, erase_avg_q, erase_avg_d;
    logic                busy_q, busy_d;

    logic [2:0]          ready_c, elig_c;
    logic [CNT_WD-1:0]   sel_sum_c, sel_req_c, result_c;
    logic [CNT_WD:0]     rem_sh_c;

    // Round-robin pick: search starts at the source after the last served one.
    function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
        logic [1:0] p0, p1, p2;
        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        if (elig[p0])      return p0;
        else if (elig[p1]) return p1;
        else               return p2;
    endfunction

    assign ready_c = {i_erase_ready, i_read_ready, i_prog_ready};
    assign elig_c  = ready_c & ~lock_q;

    always_comb begin
        sel_sum_c = i_erase_cnt;
        sel_req_c = CNT_WD'(i_erase_req_cnt);
        case (grant_q)
            2'd0: begin sel_sum_c = i_prog_cnt; sel_req_c = CNT_WD'(i_prog_req_cnt); end
            2'd1: begin sel_sum_c = i_read_cnt; sel_req_c = CNT_WD'(i_read_req_cnt); end
            default: ;
        endcase
    end

    always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
        if (i_bus_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'd0;
            last_q      <= 2'd2;
            lock_q      <= '0;
            valid_q     <= '0;
            cp_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            div_cnt_q   <= '0;
            prog_avg_q  <= '0;
            read_avg_q  <= '0;
            erase_avg_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            valid_q     <= valid_d;
            cp_q        <= cp_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            div_cnt_q   <= div_cnt_d;
            prog_avg_q  <= prog_avg_d;
            read_avg_q  <= read_avg_d;
            erase_avg_q <= erase_avg_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|elig_c) state_d = ST_LATCH;
            ST_LATCH: state_d = (sel_req_c == '0) ? ST_STORE : ST_DIV;
            ST_DIV:   if (div_cnt_q == DIV_LAST) state_d = ST_STORE;
            ST_STORE: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        last_d      = last_q;
        lock_d      = lock_q & ready_c;
        valid_d     = valid_q & ~i_clr;
        cp_d        = '0;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        div_cnt_d   = div_cnt_q;
        prog_avg_d  = prog_avg_q;
        read_avg_d  = read_avg_q;
        erase_avg_d = erase_avg_q;
        busy_d      = (state_d != ST_IDLE);
        rem_sh_c    = {rem_q[CNT_WD-1:0], quo_q[CNT_WD-1]};
        result_c    = (dvsr_q == '0) ? '0 : quo_q;
        case (state_q)
            ST_IDLE: begin
                if (|elig_c) begin
                    grant_d = rr_pick(elig_c, last_q);
                    last_d  = rr_pick(elig_c, last_q);
                end
            end
            ST_LATCH: begin
                rem_d     = '0;
                quo_d     = sel_sum_c;
                dvsr_d    = sel_req_c;
                div_cnt_d = '0;
            end
            // One restoring step: the dividend shifts out of quo as quotient bits shift in.
            ST_DIV: begin
                div_cnt_d = div_cnt_q + DIV_CW'(1);
                if (rem_sh_c >= {1'b0, dvsr_q}) begin
                    rem_d = rem_sh_c - {1'b0, dvsr_q};
                    quo_d = {quo_q[CNT_WD-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh_c;
                    quo_d = {quo_q[CNT_WD-2:0], 1'b0};
                end
            end
            ST_STORE: begin
                case (grant_q)
                    2'd0:    prog_avg_d  = result_c;
                    2'd1:    read_avg_d  = result_c;
                    default: erase_avg_d = result_c;
                endcase
                valid_d = valid_d | 3'(3'b001 << grant_q);
                cp_d    = 3'(3'b001 << grant_q);
            end
            // Lockout holds until the counter's registered ready is seen low.
            ST_ACK: lock_d = lock_d | 3'(3'b001 << grant_q);
            default: ;
        endcase
    end

    assign o_prog_cp_cmplt  = cp_q[0];
    assign o_read_cp_cmplt  = cp_q[1];
    assign o_erase_cp_cmplt = cp_q[2];
    assign o_prog_avg       = prog_avg_q;
    assign o_read_avg       = read_avg_q;
    assign o_erase_avg      = erase_avg_q;
    assign o_valid          = valid_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_performance_ch_avg_collector.sv
// Bench for performance_ch_avg_collector: directed scenarios plus randomized rounds
// checked against a round-robin/timing/average reference model.
module tb_performance_ch_avg_collector;

    localparam int unsigned CNT_WD       = 32;
    localparam int unsigned PROG_REQ_WD  = 10;
    localparam int unsigned READ_REQ_WD  = 12;
    localparam int unsigned ERASE_REQ_WD = 10;
    localparam int DIV_LAT  = 35;
    localparam int ZERO_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    logic prog_ready, read_ready, erase_ready;
    logic [CNT_WD-1:0] prog_cnt, read_cnt, erase_cnt;
    logic [PROG_REQ_WD-1:0]  prog_req;
    logic [READ_REQ_WD-1:0]  read_req;
    logic [ERASE_REQ_WD-1:0] erase_req;
    logic prog_cp, read_cp, erase_cp;
    logic [CNT_WD-1:0] prog_avg, read_avg, erase_avg;
    logic [2:0] valid, clr;
    logic busy;

    int checks = 0, errors = 0, cyc = 0, last_model = 2;
    int hold[3], rel[3];
    int ev_cyc[$], ev_src[$];
    logic [CNT_WD-1:0] ev_avg[$];

    always #5 clk = ~clk;

    performance_ch_avg_collector #(
        .CNT_WD(CNT_WD), .PROG_REQ_WD(PROG_REQ_WD),
        .READ_REQ_WD(READ_REQ_WD), .ERASE_REQ_WD(ERASE_REQ_WD)
    ) dut (
        .i_bus_clk(clk), .i_bus_rst(rst),
        .i_prog_ready(prog_ready), .i_prog_cnt(prog_cnt), .i_prog_req_cnt(prog_req),
        .o_prog_cp_cmplt(prog_cp),
        .i_read_ready(read_ready), .i_read_cnt(read_cnt), .i_read_req_cnt(read_req),
        .o_read_cp_cmplt(read_cp),
        .i_erase_ready(erase_ready), .i_erase_cnt(erase_cnt), .i_erase_req_cnt(erase_req),
        .o_erase_cp_cmplt(erase_cp),
        .o_prog_avg(prog_avg), .o_read_avg(read_avg), .o_erase_avg(erase_avg),
        .o_valid(valid), .i_clr(clr), .o_busy(busy)
    );

    function automatic logic [CNT_WD-1:0] avg_of(input int k);
        case (k)
            0:       return prog_avg;
            1:       return read_avg;
            default: return erase_avg;
        endcase
    endfunction

    task automatic set_ready(input int k, input logic v);
        case (k)
            0:       prog_ready = v;
            1:       read_ready = v;
            default: erase_ready = v;
        endcase
    endtask

    task automatic raise(input int k, input logic [CNT_WD-1:0] sum, input int unsigned req);
        case (k)
            0:       begin prog_cnt = sum;  prog_req  = PROG_REQ_WD'(req);  end
            1:       begin read_cnt = sum;  read_req  = READ_REQ_WD'(req);  end
            default: begin erase_cnt = sum; erase_req = ERASE_REQ_WD'(req); end
        endcase
        set_ready(k, 1'b1);
    endtask

    // One clock: sample outputs, log pulses, emulate the counters dropping ready after ack.
    task automatic tick();
        logic [2:0] cp;
        @(posedge clk);
        cyc++;
        #1;
        cp = {erase_cp, read_cp, prog_cp};
        checks++;
        if ($countones(cp) > 1) begin
            errors++;
            $display("FAIL cp_overlap cyc=%0d got=%b required=at most one bit", cyc, cp);
        end
        for (int k = 0; k < 3; k++) begin
            if (rel[k] > 0) begin
                rel[k]--;
                if (rel[k] == 0) set_ready(k, 1'b0);
            end
            if (cp[k]) begin
                ev_cyc.push_back(cyc);
                ev_src.push_back(k);
                ev_avg.push_back(avg_of(k));
                rel[k] = hold[k];
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_events();
        ev_cyc.delete(); ev_src.delete(); ev_avg.delete();
    endtask

    task automatic clear_valid();
        clr = 3'b111;
        tick();
        clr = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        prog_ready = 0; read_ready = 0; erase_ready = 0;
        for (int k = 0; k < 3; k++) begin rel[k] = 0; hold[k] = 1; end
        last_model = 2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_events();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({prog_cp, read_cp, erase_cp, busy} !== 4'b0 || valid !== 3'b0) begin
            errors++;
            $display("FAIL reset_ctrl got cp=%b busy=%b valid=%b required 0", {erase_cp, read_cp, prog_cp}, busy, valid);
        end
        checks++;
        if (prog_avg !== '0 || read_avg !== '0 || erase_avg !== '0) begin
            errors++;
            $display("FAIL reset_avg got %0d/%0d/%0d required 0/0/0", prog_avg, read_avg, erase_avg);
        end
        run(3);
        checks++;
        if (busy !== 1'b0 || ev_cyc.size() != 0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b pulses=%0d required 0/0", busy, ev_cyc.size());
        end
    endtask

    task automatic test_prog_basic();
        int t0, busy_bad;
        clear_valid(); clear_events();
        busy_bad = 0;
        raise(0, 32'd25000, 10);
        t0 = cyc;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy !== ((i >= 1) && (i <= DIV_LAT))) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL prog_busy got %0d wrong busy cycles required 0", busy_bad);
        end
        checks++;
        if (ev_cyc.size() != 1 || ev_cyc[0] != t0 + DIV_LAT || ev_src[0] != 0) begin
            errors++;
            $display("FAIL prog_pulse got n=%0d cyc=%0d required n=1 cyc=%0d", ev_cyc.size(),
                     ev_cyc.size() > 0 ? ev_cyc[0] - t0 : -1, DIV_LAT);
        end
        checks++;
        if (prog_avg !== 32'd2500 || valid !== 3'b001) begin
            errors++;
            $display("FAIL prog_avg got avg=%0d valid=%b required 2500/001", prog_avg, valid);
        end
        last_model = 0;
    endtask

    task automatic test_div_zero();
        int t0;
        clear_valid(); clear_events();
        raise(1, 32'd100, 0);
        t0 = cyc;
        run(8);
        checks++;
        if (ev_cyc.size() != 1 || ev_cyc[0] != t0 + ZERO_LAT || ev_src[0] != 1) begin
            errors++;
            $display("FAIL zero_pulse got n=%0d cyc=%0d required n=1 cyc=%0d", ev_cyc.size(),
                     ev_cyc.size() > 0 ? ev_cyc[0] - t0 : -1, ZERO_LAT);
        end
        checks++;
        if (read_avg !== '0 || valid !== 3'b010 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_avg got avg=%0d valid=%b busy=%b required 0/010/0", read_avg, valid, busy);
        end
        last_model = 1;
    endtask

    task automatic test_all_three();
        int t0;
        int exp_cyc[3];
        logic [CNT_WD-1:0] exp_avg[3];
        do_reset();
        clear_events();
        exp_avg[0] = 250; exp_avg[1] = 300; exp_avg[2] = 10;
        exp_cyc[0] = 35;  exp_cyc[1] = 71;  exp_cyc[2] = 107;
        raise(0, 32'd1000, 4); raise(1, 32'd900, 3); raise(2, 32'd50, 5);
        t0 = cyc;
        run(115);
        checks++;
        if (ev_cyc.size() != 3) begin
            errors++;
            $display("FAIL all3_count got %0d pulses required 3", ev_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ev_src[i] != i || ev_cyc[i] - t0 != exp_cyc[i] || ev_avg[i] !== exp_avg[i]) begin
                    errors++;
                    $display("FAIL all3_ev%0d got src=%0d cyc=%0d avg=%0d required src=%0d cyc=%0d avg=%0d",
                             i, ev_src[i], ev_cyc[i] - t0, ev_avg[i], i, exp_cyc[i], exp_avg[i]);
                end
            end
        end
        last_model = 2;
    endtask

    task automatic test_lockout();
        int t0;
        clear_valid(); clear_events();
        hold[0] = 2;
        raise(0, 32'd1200, 6);
        run(DIV_LAT + 50);
        hold[0] = 1;
        checks++;
        if (ev_cyc.size() != 1 || prog_avg !== 32'd200) begin
            errors++;
            $display("FAIL lockout_double got pulses=%0d avg=%0d required 1/200", ev_cyc.size(), prog_avg);
        end
        clear_events();
        raise(0, 32'd999, 3);
        t0 = cyc;
        run(40);
        checks++;
        if (ev_cyc.size() != 1 || ev_cyc[0] != t0 + DIV_LAT || prog_avg !== 32'd333) begin
            errors++;
            $display("FAIL lockout_rearm got pulses=%0d avg=%0d required 1/333", ev_cyc.size(), prog_avg);
        end
        last_model = 0;
    endtask

    task automatic test_reset_mid_div();
        int t0;
        clear_valid(); clear_events();
        raise(0, 32'd7777, 7);
        run(12);
        rst = 1'b1;
        prog_ready = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || prog_avg !== '0 || valid !== 3'b0 || prog_cp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b avg=%0d valid=%b required 0/0/000", busy, prog_avg, valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_model = 2;
        run(40);
        checks++;
        if (ev_cyc.size() != 0 || prog_avg !== '0 || valid !== 3'b0) begin
            errors++;
            $display("FAIL rst_abort got pulses=%0d avg=%0d valid=%b required 0/0/000", ev_cyc.size(), prog_avg, valid);
        end
        raise(0, 32'd7777, 7);
        t0 = cyc;
        run(40);
        checks++;
        if (ev_cyc.size() != 1 || ev_cyc[0] != t0 + DIV_LAT || prog_avg !== 32'd1111 || valid !== 3'b001) begin
            errors++;
            $display("FAIL rst_recover got pulses=%0d avg=%0d valid=%b required 1/1111/001", ev_cyc.size(), prog_avg, valid);
        end
        last_model = 0;
    endtask

    task automatic test_clr_collision();
        int t0;
        clear_valid(); clear_events();
        raise(0, 32'd900, 9);
        t0 = cyc;
        run(DIV_LAT - 1);
        clr = 3'b001;
        tick();
        checks++;
        if (valid[0] !== 1'b1 || prog_cp !== 1'b1) begin
            errors++;
            $display("FAIL clr_set_wins got valid=%b cp=%b required valid[0]=1 cp=1", valid, prog_cp);
        end
        tick();
        clr = 3'b000;
        checks++;
        if (valid[0] !== 1'b0 || prog_avg !== 32'd100) begin
            errors++;
            $display("FAIL clr_later got valid=%b avg=%0d required valid[0]=0 avg=100", valid, prog_avg);
        end
        run(4);
        last_model = 0;
    endtask

    // Randomized rounds: model predicts round-robin order, pulse cycles and truncated averages.
    task automatic test_random();
        int t0, ptr, prev, k, mask;
        logic [CNT_WD-1:0] sum[3];
        int unsigned req[3];
        int unsigned req_max[3];
        int exp_src[$], exp_cyc[$];
        logic [CNT_WD-1:0] exp_avg[$];
        req_max[0] = 1023; req_max[1] = 4095; req_max[2] = 1023;
        for (int it = 0; it < 8; it++) begin
            clear_valid(); clear_events();
            exp_src.delete(); exp_cyc.delete(); exp_avg.delete();
            mask = int'($urandom_range(1, 7));
            for (int s = 0; s < 3; s++) begin
                sum[s] = $urandom;
                req[s] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, req_max[s]);
                if (mask[s]) raise(s, sum[s], req[s]);
            end
            t0 = cyc;
            ptr = last_model;
            prev = t0 - 1;
            for (int n = 0; n < $countones(mask); n++) begin
                k = ptr;
                for (int s = 1; s <= 3; s++) begin
                    k = (ptr + s) % 3;
                    if (mask[k] && !(k inside {exp_src})) break;
                end
                prev = prev + 1 + ((req[k] == 0) ? ZERO_LAT : DIV_LAT);
                exp_src.push_back(k);
                exp_cyc.push_back(prev);
                exp_avg.push_back((req[k] == 0) ? '0 : sum[k] / CNT_WD'(req[k]));
                ptr = k;
            end
            run(prev - t0 + 5);
            last_model = ptr;
            checks++;
            if (ev_cyc.size() != exp_cyc.size()) begin
                errors++;
                $display("FAIL rnd%0d_count got %0d pulses required %0d", it, ev_cyc.size(), exp_cyc.size());
            end else begin
                for (int i = 0; i < exp_cyc.size(); i++) begin
                    checks++;
                    if (ev_src[i] != exp_src[i] || ev_cyc[i] != exp_cyc[i] || ev_avg[i] !== exp_avg[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_ev%0d got src=%0d cyc=%0d avg=%0d required src=%0d cyc=%0d avg=%0d",
                                 it, i, ev_src[i], ev_cyc[i] - t0, ev_avg[i], exp_src[i], exp_cyc[i] - t0, exp_avg[i]);
                    end
                end
            end
            checks++;
            if (valid !== 3'(mask) || busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_valid got valid=%b busy=%b required %b/0", it, valid, busy, 3'(mask));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 3'b000;
        prog_ready = 0; read_ready = 0; erase_ready = 0;
        prog_cnt = '0; read_cnt = '0; erase_cnt = '0;
        prog_req = '0; read_req = '0; erase_req = '0;
        test_reset();
        test_prog_basic();
        test_div_zero();
        test_all_three();
        test_lockout();
        test_reset_mid_div();
        test_clr_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
